// File: rtl/seg_mux_2digit.sv
// Two-digit time-multiplexed 7-segment driver; digits are snapshotted per frame so a frame never mixes old and new values.
// Latency: new digit values appear at the start of the frame after capture; no backpressure (free-running scan, frozen by enable).
module seg_mux_2digit #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [0:6] dec10s,
  input  logic [0:6] dec1s,
  input  logic       blankZero,
  output logic [0:6] segOut,
  output logic [1:0] anode,
  output logic       frameStart
);

  localparam int             CW       = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [0:6]     ZERO_PAT = 7'b1111110;

  typedef enum logic {TENS = 1'b0, ONES = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [0:6]    snap10, snap1;
  logic          wrap, capture;

  always_comb begin
    wrap      = enable && (cnt == CNT_LAST);
    capture   = wrap && (state == ONES);
    cnt_nxt   = cnt;
    state_nxt = state;
    if (enable) begin
      cnt_nxt = wrap ? '0 : cnt + CW'(1);
    end
    if (wrap) begin
      state_nxt = (state == TENS) ? ONES : TENS;
    end
  end

  // Snapshot on the last cycle of the ONES phase so the next frame shows one coherent pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= TENS;
      cnt    <= '0;
      snap10 <= '0;
      snap1  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        snap10 <= dec10s;
        snap1  <= dec1s;
      end
    end
  end

  always_comb begin
    segOut     = '0;
    anode      = 2'b11;
    frameStart = 1'b0;
    if (enable) begin
      case (state)
        TENS: begin
          anode      = 2'b01;
          segOut     = (blankZero && (snap10 == ZERO_PAT)) ? 7'b0000000 : snap10;
          frameStart = (cnt == '0);
        end
        default: begin
          anode  = 2'b10;
          segOut = snap1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_mux_2digit.sv
// Bench for seg_mux_2digit at DIV=4 and DIV=2 against a frame-level reference model.
module tb_seg_mux_2digit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, blankZero;
  logic [0:6] dec10s, dec1s;
  logic [0:6] seg4, seg2;
  logic [1:0] an4, an2;
  logic       fs4, fs2;

  int errors = 0;
  int checks = 0;

  // Model state: enabled cycles since reset, and the pair shown in the current frame.
  int         k4, k2;
  logic [0:6] m10_4, m1_4, m10_2, m1_2;

  seg_mux_2digit #(.DIV(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .dec10s(dec10s), .dec1s(dec1s),
    .blankZero(blankZero), .segOut(seg4), .anode(an4), .frameStart(fs4)
  );

  seg_mux_2digit #(.DIV(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .dec10s(dec10s), .dec1s(dec1s),
    .blankZero(blankZero), .segOut(seg2), .anode(an2), .frameStart(fs2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame position pos in 0..2D-1: first D cycles show tens, last D show ones.
  task automatic model_out(input int d, input int k, input logic [0:6] s10, input logic [0:6] s1,
                           input logic en, input logic bz,
                           output logic [0:6] seg, output logic [1:0] an, output logic fs);
    int pos;
    pos = k % (2 * d);
    seg = 7'b0000000;
    an  = 2'b11;
    fs  = 1'b0;
    if (en) begin
      if (pos < d) begin
        an  = 2'b01;
        seg = (bz && s10 == 7'b1111110) ? 7'b0000000 : s10;
        fs  = (pos == 0);
      end else begin
        an  = 2'b10;
        seg = s1;
      end
    end
  endtask

  task automatic model_step(input int d, inout int k, inout logic [0:6] s10, inout logic [0:6] s1);
    if (reset) begin
      k   = 0;
      s10 = 7'b0000000;
      s1  = 7'b0000000;
    end else if (enable) begin
      if (k % (2 * d) == 2 * d - 1) begin
        s10 = dec10s;
        s1  = dec1s;
      end
      k++;
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic bz,
                       input logic [0:6] t, input logic [0:6] o,
                       input bit dchk = 1'b0, input logic [0:6] dseg = '0, input logic [1:0] dan = '0);
    logic [0:6] eseg;
    logic [1:0] ean;
    logic       efs;
    @(negedge clk);
    reset = r; enable = en; blankZero = bz; dec10s = t; dec1s = o;
    #1;
    model_out(4, k4, m10_4, m1_4, en, bz, eseg, ean, efs);
    chk("div4_seg", seg4, eseg);
    chk("div4_anode", an4, ean);
    chk("div4_frame", fs4, efs);
    model_out(2, k2, m10_2, m1_2, en, bz, eseg, ean, efs);
    chk("div2_seg", seg2, eseg);
    chk("div2_anode", an2, ean);
    chk("div2_frame", fs2, efs);
    chk("div2_no_both_on", (an2 == 2'b00), 1'b0);
    if (dchk) begin
      chk("dir_seg", seg4, dseg);
      chk("dir_anode", an4, dan);
    end
    @(posedge clk);
    model_step(4, k4, m10_4, m1_4);
    model_step(2, k2, m10_2, m1_2);
  endtask

  localparam logic [0:6] P1 = 7'b0110000, P2 = 7'b1101101;
  localparam logic [0:6] P6 = 7'b1011111, P7 = 7'b1110000, P0 = 7'b1111110;

  initial begin
    reset = 1'b1; enable = 1'b1; blankZero = 1'b0; dec10s = '0; dec1s = '0;
    k4 = 0; k2 = 0; m10_4 = '0; m1_4 = '0; m10_2 = '0; m1_2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_anode", an4, 2'b01);
    chk("rst_seg", seg4, 7'b0000000);
    chk("rst_frame", fs4, 1'b1);

    // Counting "12" then "67" from cycle 13.
    cycle(1'b1, 1'b1, 1'b0, P1, P2);
    for (int i = 0; i < 24; i++) begin
      logic [0:6] t, o;
      t = (i < 13) ? P1 : P6;
      o = (i < 13) ? P2 : P7;
      case (i)
        0:       cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, 7'b0000000, 2'b01);
        4:       cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, 7'b0000000, 2'b10);
        8:       cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, P1, 2'b01);
        13:      cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, P2, 2'b10);
        16:      cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, P6, 2'b01);
        20:      cycle(1'b0, 1'b1, 1'b0, t, o, 1'b1, P7, 2'b10);
        default: cycle(1'b0, 1'b1, 1'b0, t, o);
      endcase
    end

    // Leading-zero blanking on "07".
    cycle(1'b1, 1'b1, 1'b1, P0, P7);
    for (int i = 0; i < 24; i++) begin
      logic bz;
      bz = (i < 16);
      case (i)
        8:       cycle(1'b0, 1'b1, bz, P0, P7, 1'b1, 7'b0000000, 2'b01);
        12:      cycle(1'b0, 1'b1, bz, P0, P7, 1'b1, P7, 2'b10);
        16:      cycle(1'b0, 1'b1, bz, P0, P7, 1'b1, P0, 2'b01);
        default: cycle(1'b0, 1'b1, bz, P0, P7);
      endcase
    end

    // Enable gap at cycles 10-12: scan freezes and resumes.
    cycle(1'b1, 1'b1, 1'b0, P1, P2);
    for (int i = 0; i < 24; i++) begin
      logic en;
      en = !(i >= 10 && i <= 12);
      case (i)
        11:      cycle(1'b0, en, 1'b0, P1, P2, 1'b1, 7'b0000000, 2'b11);
        13:      cycle(1'b0, en, 1'b0, P1, P2, 1'b1, P1, 2'b01);
        15:      cycle(1'b0, en, 1'b0, P1, P2, 1'b1, P2, 2'b10);
        default: cycle(1'b0, en, 1'b0, P1, P2);
      endcase
    end

    // Reset pulsed mid-frame at cycle 14.
    cycle(1'b1, 1'b1, 1'b0, P6, P7);
    for (int i = 0; i < 34; i++) begin
      case (i)
        14:      cycle(1'b1, 1'b1, 1'b0, P6, P7);
        15:      cycle(1'b0, 1'b1, 1'b0, P6, P7, 1'b1, 7'b0000000, 2'b01);
        20:      cycle(1'b0, 1'b1, 1'b0, P6, P7, 1'b1, 7'b0000000, 2'b10);
        23:      cycle(1'b0, 1'b1, 1'b0, P6, P7, 1'b1, P6, 2'b01);
        default: cycle(1'b0, 1'b1, 1'b0, P6, P7);
      endcase
    end

    // Randomized run: sporadic reset, enable gaps, changing digits, zero tens.
    for (int i = 0; i < 1500; i++) begin
      logic       r, en, bz;
      logic [0:6] t, o;
      r  = ($urandom_range(0, 63) == 0);
      en = ($urandom_range(0, 7) != 0);
      bz = $urandom_range(0, 1) != 0;
      t  = ($urandom_range(0, 3) == 0) ? P0 : 7'($urandom);
      o  = 7'($urandom);
      cycle(r, en, bz, t, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
